// File: rtl/lrwait_tcdm_queue.sv
// Memory-side LRwait/MCS lock queue in front of one TCDM bank.
// Tracks lock head/tail per address; forwards all other traffic.
module lrwait_tcdm_queue #(
  parameter int NumSlots      = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int MetaWidth     = 16,
  parameter int BankAddrWidth = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [AddrWidth-1:0]     in_addr_i,
  input  logic                     in_write_i,
  input  logic [3:0]               in_amo_i,
  input  logic [DataWidth-1:0]     in_wdata_i,
  input  logic [DataWidth/8-1:0]   in_be_i,
  input  logic [MetaWidth-1:0]     in_meta_i,
  input  logic                     in_lrwait_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DataWidth-1:0]     out_rdata_o,
  output logic [MetaWidth-1:0]     out_meta_o,
  output logic                     out_lrwait_o,
  output logic                     bank_req_o,
  output logic                     bank_we_o,
  output logic [BankAddrWidth-1:0] bank_addr_o,
  output logic [DataWidth-1:0]     bank_wdata_o,
  output logic [DataWidth/8-1:0]   bank_be_o,
  input  logic [DataWidth-1:0]     bank_rdata_i
);

  localparam int SW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int TW = AddrWidth - 2;

  typedef enum logic {Idle, Resp} state_e;
  state_e state_q, state_d;

  logic [NumSlots-1:0]  valid_q, hv_q;
  logic [TW-1:0]        addr_q [NumSlots];
  logic [MetaWidth-1:0] head_q [NumSlots];
  logic [MetaWidth-1:0] tail_q [NumSlots];

  logic [TW-1:0]        tag;
  logic                 hit, free;
  logic [SW-1:0]        hit_idx, free_idx;
  logic                 is_wake, is_lrq, is_sc, sc_ok;
  logic                 accept, rsp, rsp_bank, rsp_lrw, breq, bwe;
  logic [MetaWidth-1:0] rsp_meta;
  logic [DataWidth-1:0] imm, meta_ext;
  logic                 do_alloc, do_tail, do_free, do_hand, do_wake;

  logic [DataWidth-1:0] rdata_q;
  logic [MetaWidth-1:0] meta_q;
  logic                 lrw_q, fresh_q;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^in_addr_i[1:0];
  assign tag = in_addr_i[AddrWidth-1:2];

  assign out_valid_o  = (state_q == Resp);
  assign in_ready_o   = !rst_i && (!out_valid_o || out_ready_i);
  assign accept       = in_valid_i && in_ready_o;
  assign out_meta_o   = meta_q;
  assign out_lrwait_o = lrw_q;
  // Bank data is live only in the first response cycle; later cycles replay the capture.
  assign out_rdata_o  = fresh_q ? bank_rdata_i : rdata_q;

  assign bank_req_o   = accept && breq;
  assign bank_we_o    = accept && bwe;
  assign bank_addr_o  = in_addr_i[BankAddrWidth+1:2];
  assign bank_wdata_o = in_wdata_i;
  assign bank_be_o    = in_be_i;

  assign is_wake = in_lrwait_i && (in_amo_i == 4'hA);
  assign is_lrq  = !in_lrwait_i && (in_amo_i == 4'hA);
  assign is_sc   = (in_amo_i == 4'hB);

  always_comb begin
    meta_ext = '0;
    meta_ext[MetaWidth-1:0] = in_meta_i;
  end

  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == tag) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  assign sc_ok = hit && hv_q[hit_idx] && (head_q[hit_idx] == in_meta_i);

  always_comb begin
    rsp      = 1'b0;
    rsp_bank = 1'b0;
    rsp_lrw  = 1'b0;
    rsp_meta = in_meta_i;
    imm      = '0;
    breq     = 1'b0;
    bwe      = 1'b0;
    do_alloc = 1'b0;
    do_tail  = 1'b0;
    do_free  = 1'b0;
    do_hand  = 1'b0;
    do_wake  = 1'b0;
    unique case (1'b1)
      is_wake: begin
        if (hit && !hv_q[hit_idx]) begin
          do_wake  = 1'b1;
          rsp      = 1'b1;
          rsp_bank = 1'b1;
          breq     = 1'b1;
          rsp_meta = in_wdata_i[MetaWidth-1:0];
        end
      end
      is_lrq: begin
        rsp = 1'b1;
        if (hit) begin
          do_tail  = 1'b1;
          rsp_lrw  = 1'b1;
          rsp_meta = tail_q[hit_idx];
          imm      = meta_ext;
        end else begin
          rsp_bank = 1'b1;
          breq     = 1'b1;
          do_alloc = free;
        end
      end
      is_sc: begin
        rsp = 1'b1;
        if (sc_ok) begin
          breq    = 1'b1;
          bwe     = 1'b1;
          do_free = (tail_q[hit_idx] == head_q[hit_idx]);
          do_hand = (tail_q[hit_idx] != head_q[hit_idx]);
        end else begin
          imm = {{(DataWidth-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        rsp      = 1'b1;
        rsp_bank = 1'b1;
        breq     = 1'b1;
        bwe      = in_write_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: if (accept && rsp) state_d = Resp;
      Resp: if (out_ready_i) state_d = (accept && rsp) ? Resp : Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      rdata_q <= '0;
      meta_q  <= '0;
      lrw_q   <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fresh_q) rdata_q <= bank_rdata_i;
      fresh_q <= 1'b0;
      if (accept && rsp) begin
        meta_q  <= rsp_meta;
        lrw_q   <= rsp_lrw;
        fresh_q <= rsp_bank;
        if (!rsp_bank) rdata_q <= imm;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      hv_q    <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        addr_q[i] <= '0;
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else if (accept) begin
      if (do_alloc) begin
        valid_q[free_idx] <= 1'b1;
        hv_q[free_idx]    <= 1'b1;
        addr_q[free_idx]  <= tag;
        head_q[free_idx]  <= in_meta_i;
        tail_q[free_idx]  <= in_meta_i;
      end
      if (do_tail) tail_q[hit_idx] <= in_meta_i;
      if (do_free) valid_q[hit_idx] <= 1'b0;
      if (do_hand) hv_q[hit_idx] <= 1'b0;
      if (do_wake) begin
        head_q[hit_idx] <= in_wdata_i[MetaWidth-1:0];
        hv_q[hit_idx]   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lrwait_tcdm_queue.md
Name: lrwait_tcdm_queue

Overview:
- Memory-side half of the distributed LRwait/MCS lock. It sits between the tile interconnect and one TCDM bank.
- Holds a small reservation table. Each entry records the current lock holder (head) and the queue tail for one address.
- Issues SuccUpdate responses to a queue's current tail, and services WakeUp requests from the per-core queue nodes by returning LR data to the successor.
- Plain loads, stores and AMOs pass to the bank unchanged.

Parameters:
- NumSlots, 4, number of reservation table entries.
- AddrWidth, 32, request address width; match on addr[AddrWidth-1:2].
- DataWidth, 32, data width.
- MetaWidth, 16, width of the routing metadata that identifies a requester (≤ DataWidth).
- BankAddrWidth, 10, bank word address width; equals addr[BankAddrWidth+1:2].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request ready
- in_addr_i  in  AddrWidth  byte address
- in_write_i  in  1  store
- in_amo_i  in  4  AMO code (0 none, A LR, B SC)
- in_wdata_i  in  DataWidth  write data; on WakeUp, successor metadata in [MetaWidth-1:0]
- in_be_i  in  DataWidth/8  byte enables
- in_meta_i  in  MetaWidth  requester routing metadata
- in_lrwait_i  in  1  request is a WakeUp
- out_valid_o  out  1  response valid
- out_ready_i  in  1  response ready
- out_rdata_o  out  DataWidth  response data
- out_meta_o  out  MetaWidth  response destination
- out_lrwait_o  out  1  response is a SuccUpdate
- bank_req_o  out  1  bank access
- bank_we_o  out  1  bank write
- bank_addr_o  out  BankAddrWidth  bank word address
- bank_wdata_o  out  DataWidth  bank write data
- bank_be_o  out  DataWidth/8  bank byte enables
- bank_rdata_i  in  DataWidth  read data, valid 1 cycle after bank_req_o

Behaviour:
- Reset (async, rst_i=1):
  - All entries invalid.
  - out_valid_o=0, out_lrwait_o=0, out_rdata_o=0, out_meta_o=0, bank_req_o=0, in_ready_o=0 while reset is asserted.
  - Reset mid-operation drops any pending response.
- Handshakes:
  - in_ready_o = !out_valid_o || out_ready_i.
  - At most one request is accepted per cycle, and every accepted request produces at most one response.
  - A request accepted in cycle t drives the bank in cycle t; out_valid_o rises at t+1.
  - While out_valid_o && !out_ready_i, all out_* signals hold stable, including captured read data.
- Entry fields: valid, addr, head_meta, head_valid, tail_meta.
- Plain load, store or AMO (not LR/SC, lrwait=0):
  - Forwarded to the bank.
  - Response carries bank_rdata_i with out_meta_o=in_meta_i, out_lrwait_o=0.
  - The reservation table is untouched.
- LR, no matching entry, free slot exists:
  - Allocate the lowest free slot: head=tail=in_meta_i, head_valid=1.
  - Bank read; data response to the requester.
- LR, no matching entry, table full:
  - Served as a plain load, with no reservation recorded.
  - A later SC from that requester fails.
- LR, matching entry exists:
  - No bank access.
  - SuccUpdate response: out_lrwait_o=1, out_meta_o=old tail_meta, out_rdata_o=zero-extended in_meta_i.
  - Then tail_meta := in_meta_i.
  - The requester receives no response now; it is served later by a WakeUp.
- SC, matching entry with head_valid && head_meta==in_meta_i:
  - Bank write; response rdata=0 (success).
  - If tail_meta==head_meta, free the entry.
  - Otherwise set head_valid=0 (handover pending).
- SC, any other case:
  - No bank write; response rdata=1 (fail).
- WakeUp (in_lrwait_i=1, amo=LR):
  - Matching entry with head_valid=0:
    - head_meta := in_wdata_i[MetaWidth-1:0], head_valid=1.
    - Bank read; data response with out_meta_o=successor, out_lrwait_o=0.
  - No matching entry, or head_valid=1: request is consumed, with no bank access and no response.
- Simultaneous events: a single input port, so no same-cycle conflicts. Table updates commit at request acceptance.
- The FSM has states Idle and Resp:
  - Idle→Resp on any accept that produces a response.
  - Resp→Idle on out_ready_i with no new accept.
  - Resp→Resp on out_ready_i together with a new accept.

Test Plan:
- LR A (meta 5) to 0x100, bank holds 0x2A → data response rdata=0x2A, meta=5, lrwait=0. Then SC A writes 0x2B → rdata=0, bank=0x2B, entry freed.
- LR A (5), then LR B (7) to 0x100 → second response lrwait=1, meta=5, rdata=7; no bank read for B.
- Continue: SC A → rdata=0. Then WakeUp data=7 → bank read; response meta=7, lrwait=0, rdata=stored value; head becomes 7. SC B → success, entry freed.
- SC by B (7) while A (5) holds 0x100 → rdata=1, no bank write. SC to an unreserved address → rdata=1.
- 5 LRs to distinct addresses with NumSlots=4 → fifth served as a plain load; its SC → rdata=1.
- Hold out_ready_i=0 for 3 cycles → in_ready_o=0 and outputs stable. Assert rst_i mid-response → out_valid_o=0 immediately; a subsequent SC fails.
